// File: rtl/mem_port_pkg.sv
// Shared types and helpers for the mem_port load/store initiator.
// Provides the FSM state encoding, lane/counter widths and the byte lane helpers.
// Lanes are little-endian: lane n occupies bits [8n+7:8n] of a word.
package mem_port_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    WR      = 3'd2,
    WR_WAIT = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam int LANE_W = 2;
  localparam int CNT_W  = 8;

  // Pick byte lane 'sel' out of a word.
  function automatic logic [7:0] byte_lane(input logic [31:0] word,
                                           input logic [LANE_W-1:0] sel);
    return word[{sel, 3'b000} +: 8];
  endfunction

  // Replace byte lane 'sel' of a word with 'b'.
  function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                             input logic [LANE_W-1:0] sel,
                                             input logic [7:0] b);
    logic [31:0] w;
    w = word;
    w[{sel, 3'b000} +: 8] = b;
    return w;
  endfunction

endpackage

// File: rtl/mem_port_lane.sv
// Byte lane datapath: extracts a load byte and merges a store byte into a word.
// Latency: purely combinational, no state.
// Backpressure: none; sign extension of byte loads when MEM_PORT_BYTE_SIGNEXT_EN is defined.
module mem_port_lane
  import mem_port_pkg::*;
(
  input  logic [31:0]       word,
  input  logic [LANE_W-1:0] sel,
  input  logic [7:0]        wr_byte,
  output logic [31:0]       load_ext,
  output logic [31:0]       merged
);

  logic [7:0] lane;

  // Extend the selected lane for loads and build the read-modify-write word for stores.
  always_comb begin
    lane = byte_lane(word, sel);
`ifdef MEM_PORT_BYTE_SIGNEXT_EN
    load_ext = {{24{lane[7]}}, lane};
`else
    load_ext = {24'h000000, lane};
`endif
    merged = merge_byte(word, sel, wr_byte);
  end

endmodule

// File: rtl/mem_port.sv
// CPU-side load/store initiator for the word-addressed memory, byte stores via read-modify-write.
// Latency: load 2 cycles accept->resp at READ_LATENCY=1 with mem_ready high; waits bounded by TIMEOUT.
// Backpressure: one request in flight; req_ready low from accept until the cycle after resp_valid.
// Optional: MEM_PORT_BYTE_SIGNEXT_EN makes byte loads sign-extend (see mem_port_lane).
module mem_port
  import mem_port_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_addr_read,
  output logic [31:0] mem_addr_write,
  output logic        mem_en_write,
  output logic [31:0] mem_data_write,
  output logic        mem_write_byte,
  input  logic [31:0] mem_out,
  input  logic        mem_ready,
  input  logic        mem_written
);

  localparam logic [CNT_W-1:0] RL_M1   = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lat_write;
  logic             lat_byte;
  logic [31:0]      lat_addr;
  // Only the low byte of store data outlives the accept cycle; word stores
  // are written straight from req_wdata when the request is accepted.
  logic [7:0]       lat_wbyte;

  logic [31:0]      lane_load;
  logic [31:0]      lane_merged;

  // The sampled memory word is consumed in the same edge it is captured:
  // it lands either in resp_rdata (loads) or mem_data_write (byte stores).
  mem_port_lane u_lane (
    .word     (mem_out),
    .sel      (lat_addr[LANE_W-1:0]),
    .wr_byte  (lat_wbyte),
    .load_ext (lane_load),
    .merged   (lane_merged)
  );

  // Request FSM with registered handshake and memory outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      lat_write      <= 1'b0;
      lat_byte       <= 1'b0;
      lat_addr       <= '0;
      lat_wbyte      <= '0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_error     <= 1'b0;
      mem_addr_read  <= '0;
      mem_addr_write <= '0;
      mem_en_write   <= 1'b0;
      mem_data_write <= '0;
      mem_write_byte <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            lat_write <= req_write;
            lat_byte  <= req_byte;
            lat_addr  <= req_addr;
            lat_wbyte <= req_wdata[7:0];
            req_ready <= 1'b0;
            cnt       <= '0;
            if (!req_byte && (req_addr[1:0] != 2'b00)) begin
              // Misaligned word access never reaches memory.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else if (req_write && !req_byte) begin
              state          <= WR;
              mem_en_write   <= 1'b1;
              mem_addr_write <= {req_addr[31:2], 2'b00};
              mem_data_write <= req_wdata;
              mem_write_byte <= 1'b0;
            end else begin
              state         <= RD_WAIT;
              mem_addr_read <= {req_addr[31:2], 2'b00};
            end
          end
        end

        RD_WAIT: begin
          if ((cnt >= RL_M1) && mem_ready) begin
            mem_addr_read <= '0;
            cnt           <= '0;
            if (lat_write) begin
              state          <= WR;
              mem_en_write   <= 1'b1;
              mem_addr_write <= {lat_addr[31:2], 2'b00};
              mem_data_write <= lane_merged;
              mem_write_byte <= lat_byte;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= lat_byte ? lane_load : mem_out;
            end
          end else if (cnt == TO_CNT) begin
            state         <= RESP;
            mem_addr_read <= '0;
            resp_valid    <= 1'b1;
            resp_error    <= 1'b1;
            resp_rdata    <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end

        WR: begin
          mem_en_write <= 1'b0;
          cnt          <= '0;
          if (mem_written) begin
            state          <= RESP;
            resp_valid     <= 1'b1;
            resp_rdata     <= '0;
            mem_addr_write <= '0;
            mem_data_write <= '0;
            mem_write_byte <= 1'b0;
          end else begin
            state <= WR_WAIT;
          end
        end

        WR_WAIT: begin
          if (mem_written || (cnt == TO_CNT)) begin
            state          <= RESP;
            resp_valid     <= 1'b1;
            resp_error     <= !mem_written;
            resp_rdata     <= '0;
            mem_addr_write <= '0;
            mem_data_write <= '0;
            mem_write_byte <= 1'b0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end

        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
